// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRelMem,
    StRelPeriph,
    StRelCore,
    StRun
  } state_e;

  // Counter width able to hold the largest of the four timing parameters.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with configurable width and reset value.
module sync_2ff #(
  parameter int unsigned       Width    = 1,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rst_seq.sv
// PLL reset sequencer: PLL reset/lock supervision and staggered domain reset release.
// Define RST_SEQ_STATUS_EN to add saturating lock-loss and PLL-retry counters.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYC  = 4,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned STABLE_CYC   = 256,
  parameter int unsigned STAGGER      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  output logic       pll_areset,
  output logic       rst_mem_n,
  output logic       rst_periph_n,
  output logic       rst_core_n,
  output logic       ready
`ifdef RST_SEQ_STATUS_EN
  ,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] pll_retry_cnt
`endif
);

  localparam int unsigned CntW = cnt_width(PLL_RST_CYC, LOCK_TIMEOUT, STABLE_CYC, STAGGER);
  localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYC - 1);
  localparam logic [CntW-1:0] StaggerLast = CntW'(STAGGER - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            locked_s;
  logic            lock_lost, timeout, sw_rst;
  logic            pll_areset_q, rst_mem_n_q, rst_periph_n_q, rst_core_n_q, ready_q;
  logic            pll_areset_d, rst_mem_n_d, rst_periph_n_d, rst_core_n_d, ready_d;

  sync_2ff #(
    .Width   (1),
    .ResetVal(1'b0)
  ) u_sync_locked (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pll_locked),
    .q    (locked_s)
  );

  assign lock_lost = !locked_s && (state_q inside {StRelMem, StRelPeriph, StRelCore, StRun});
  assign timeout   = (state_q == StWaitLock) && !locked_s && (cnt_q == TimeoutLast);
  // Lock loss outranks a simultaneous software request.
  assign sw_rst    = (state_q == StRun) && sw_rst_req && !lock_lost;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPllRst:    if (cnt_q == PllRstLast) state_d = StWaitLock;
      StWaitLock:  if (locked_s) state_d = StStable;
                   else if (timeout) state_d = StPllRst;
      StStable:    if (!locked_s) state_d = StWaitLock;
                   else if (cnt_q == StableLast) state_d = StRelMem;
      StRelMem:    if (lock_lost) state_d = StWaitLock;
                   else if (cnt_q == StaggerLast) state_d = StRelPeriph;
      StRelPeriph: if (lock_lost) state_d = StWaitLock;
                   else if (cnt_q == StaggerLast) state_d = StRelCore;
      StRelCore:   if (lock_lost) state_d = StWaitLock;
                   else if (cnt_q == StaggerLast) state_d = StRun;
      StRun:       if (lock_lost) state_d = StWaitLock;
                   else if (sw_rst) state_d = StRelPeriph;
      default:     state_d = StPllRst;
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

    // Outputs are registered from the next state so each release lands on the entry edge.
    pll_areset_d   = (state_d == StPllRst);
    rst_mem_n_d    = state_d inside {StRelMem, StRelPeriph, StRelCore, StRun};
    rst_periph_n_d = (state_d inside {StRelPeriph, StRelCore, StRun}) && !sw_rst;
    rst_core_n_d   = state_d inside {StRelCore, StRun};
    ready_d        = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StPllRst;
      cnt_q          <= '0;
      pll_areset_q   <= 1'b1;
      rst_mem_n_q    <= 1'b0;
      rst_periph_n_q <= 1'b0;
      rst_core_n_q   <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pll_areset_q   <= pll_areset_d;
      rst_mem_n_q    <= rst_mem_n_d;
      rst_periph_n_q <= rst_periph_n_d;
      rst_core_n_q   <= rst_core_n_d;
      ready_q        <= ready_d;
    end
  end

  assign pll_areset   = pll_areset_q;
  assign rst_mem_n    = rst_mem_n_q;
  assign rst_periph_n = rst_periph_n_q;
  assign rst_core_n   = rst_core_n_q;
  assign ready        = ready_q;

`ifdef RST_SEQ_STATUS_EN
  logic [7:0] lock_loss_q, pll_retry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_q <= '0;
      pll_retry_q <= '0;
    end else begin
      if (lock_lost && (lock_loss_q != 8'hff)) lock_loss_q <= lock_loss_q + 8'd1;
      if (timeout && (pll_retry_q != 8'hff)) pll_retry_q <= pll_retry_q + 8'd1;
    end
  end

  assign lock_loss_cnt = lock_loss_q;
  assign pll_retry_cnt = pll_retry_q;
`endif

endmodule
